// File: rtl/crc_stream_engine.sv
// Parametrised streaming CRC engine: framed valid/ready input beats, one registered CRC per frame.
// Define CRC_CHECK_EN to register a residue check on crc_ok; otherwise crc_ok is tied low.
module crc_stream_engine #(
    parameter int unsigned      DATA_W  = 8,
    parameter int unsigned      CRC_W   = 8,
    parameter logic [CRC_W-1:0] POLY    = 'h07,
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOR_OUT = '0,
    parameter bit               REFIN   = 1'b0,
    parameter bit               REFOUT  = 1'b0,
    parameter logic [CRC_W-1:0] RESIDUE = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_vld,
    output logic                s_rdy,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_sop,
    input  logic                s_eop,
    input  logic [DATA_W/8-1:0] s_keep,
    output logic                crc_vld,
    input  logic                crc_rdy,
    output logic [CRC_W-1:0]    crc_out,
    output logic                crc_ok,
    output logic                err_nosop,
    output logic                busy
);
    localparam int unsigned NB = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state, state_nxt;
    logic [CRC_W-1:0] crc_reg, crc_calc, crc_post;
    logic             accept, take;

    function automatic logic [7:0] reflect8(input logic [7:0] v);
        logic [7:0] r;
        for (int unsigned i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] reflect_crc(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        for (int unsigned i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
        return r;
    endfunction

    // Reflected input is handled by bit-reversing the byte and running the MSB-first register.
    function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c, input logic [7:0] b);
        logic [CRC_W-1:0] r;
        logic [7:0]       d;
        d = REFIN ? reflect8(b) : b;
        r = c ^ (CRC_W'(d) << (CRC_W - 8));
        for (int unsigned k = 0; k < 8; k++)
            r = r[CRC_W-1] ? ((r << 1) ^ POLY) : (r << 1);
        return r;
    endfunction

    assign s_rdy  = (state != HOLD);
    assign accept = s_vld & s_rdy;
    // Beats in IDLE without sop are dropped and never touch the register.
    assign take   = accept & ((state != IDLE) | s_sop);

    always_comb begin
        crc_calc = s_sop ? INIT : crc_reg;
        for (int unsigned i = 0; i < NB; i++)
            if (s_keep[i]) crc_calc = crc_byte(crc_calc, s_data[DATA_W-1-8*i -: 8]);
        crc_post = (REFOUT ? reflect_crc(crc_calc) : crc_calc) ^ XOR_OUT;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (accept && s_sop) state_nxt = s_eop ? HOLD : RUN;
            RUN:     if (accept && s_eop) state_nxt = HOLD;
            HOLD:    if (crc_vld && crc_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            crc_reg   <= INIT;
            crc_out   <= '0;
            crc_vld   <= 1'b0;
            err_nosop <= 1'b0;
        end else begin
            state     <= state_nxt;
            err_nosop <= accept && (state == IDLE) && !s_sop;
            if (take) crc_reg <= crc_calc;
            if (take && s_eop) begin
                crc_out <= crc_post;
                crc_vld <= 1'b1;
            end else if (crc_vld && crc_rdy) begin
                crc_vld <= 1'b0;
            end
        end
    end

`ifdef CRC_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            crc_ok <= 1'b0;
        else if (take && s_eop)
            crc_ok <= (crc_calc == RESIDUE);
    end
`else
    logic unused_residue;
    assign unused_residue = ^RESIDUE;
    assign crc_ok         = 1'b0;
`endif

endmodule
